hazard_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use and branch-operand hazards that forwarding cannot cover, and runs the multi-cycle multiply/divide unit (MDU) start/done handshake. It also freezes the pipeline while a data-memory access waits, and keeps a saturating stall-cycle counter. It sits beside the forwarding unit and drives the enable/clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_controller_pkg.sv | 31 +++
 rtl/hazard_controller_detect.sv | 35 +++
 rtl/hazard_controller.sv | 171 +++++++++++++++++
 tb/tb_hazard_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the controller state encoding, the control bundle and register-match helpers.
package hazard_controller_pkg;

   localparam int REG_SIZE = 5;

   typedef enum logic [1:0] {
      HZ_RUN      = 2'd0,
      HZ_MDU_WAIT = 2'd1,
      HZ_MEM_WAIT = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic stall_m;
      logic flush_e;
      logic flush_m;
      logic flush_w;
      logic mdu_start;
   } hz_ctrl_t;

   // Register 0 is hard-wired, so it never produces a dependency.
   function automatic logic reg_hit(input logic [REG_SIZE-1:0] dst,
                                    input logic [REG_SIZE-1:0] src_a,
                                    input logic [REG_SIZE-1:0] src_b);
      return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
   endfunction

endpackage

// File: rtl/hazard_controller_detect.sv
// Purely combinational load-use and branch-operand dependency detection
// for the decode stage; no state lives here.
module hazard_detect
   import hazard_controller_pkg::*;
(
   input  logic [REG_SIZE-1:0] rsD,
   input  logic [REG_SIZE-1:0] rtD,
   input  logic                branchD,
   input  logic [REG_SIZE-1:0] writeRegAddrE,
   input  logic [REG_SIZE-1:0] writeRegAddrM,
   input  logic                Regfile_weE,
   input  logic                Regfile_weM,
   input  logic                memToRegE,
   input  logic                memToRegM,
   output logic                load_use_o,
   output logic                branch_haz_o
);

   logic hit_e_s;
   logic hit_m_s;

   // Source-operand matches against the E and M destinations.
   always_comb begin
      hit_e_s = reg_hit(writeRegAddrE, rsD, rtD);
      hit_m_s = reg_hit(writeRegAddrM, rsD, rtD);
   end

   // A branch resolves in D, so it also waits for ALU results in E and load data in M.
   always_comb begin
      load_use_o   = memToRegE & Regfile_weE & hit_e_s;
      branch_haz_o = branchD & ((Regfile_weE & hit_e_s) |
                                (memToRegM & Regfile_weM & hit_m_s));
   end

endmodule

// File: rtl/hazard_controller.sv
// Central stall/flush sequencer: combines decode hazards with the MDU
// handshake and data-memory wait, and keeps a saturating stall counter.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int PERF_W      = 32
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [REG_SIZE-1:0] rsD,
   input  logic [REG_SIZE-1:0] rtD,
   input  logic                branchD,
   input  logic [REG_SIZE-1:0] writeRegAddrE,
   input  logic [REG_SIZE-1:0] writeRegAddrM,
   input  logic                Regfile_weE,
   input  logic                Regfile_weM,
   input  logic                memToRegE,
   input  logic                memToRegM,
   input  logic                mduOpE,
   input  logic                mdu_done,
   input  logic                dmem_reqM,
   input  logic                dmem_ready,
   output logic                stallF,
   output logic                stallD,
   output logic                stallE,
   output logic                stallM,
   output logic                flushE,
   output logic                flushM,
   output logic                flushW,
   output logic                mdu_start,
   output logic                mem_err,
   output logic [PERF_W-1:0]   stall_cycles
);

   localparam logic [7:0]        TO_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

   hz_state_e         state_q, state_d;
   logic [7:0]        to_cnt_q, to_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   hz_ctrl_t          ctrl_s;
   logic              load_use_s;
   logic              branch_haz_s;
   logic              mem_block_s;

   hazard_detect u_detect (
      .rsD           (rsD),
      .rtD           (rtD),
      .branchD       (branchD),
      .writeRegAddrE (writeRegAddrE),
      .writeRegAddrM (writeRegAddrM),
      .Regfile_weE   (Regfile_weE),
      .Regfile_weM   (Regfile_weM),
      .memToRegE     (memToRegE),
      .memToRegM     (memToRegM),
      .load_use_o    (load_use_s),
      .branch_haz_o  (branch_haz_s)
   );

   assign mem_block_s = dmem_reqM & ~dmem_ready;

   // Next-state, timeout and per-stage control decode.
   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      mem_err_d = mem_err_q;
      ctrl_s    = '0;
      case (state_q)
         HZ_RUN: begin
            if (mem_block_s) begin
               // Freeze everything up to M so the waiting access stays put.
               ctrl_s.stall_f = 1'b1;
               ctrl_s.stall_d = 1'b1;
               ctrl_s.stall_e = 1'b1;
               ctrl_s.stall_m = 1'b1;
               ctrl_s.flush_w = 1'b1;
               to_cnt_d       = 8'd0;
               state_d        = HZ_MEM_WAIT;
            end else if (mduOpE) begin
               // Hold the mult/div in E while it launches; done here is ignored.
               ctrl_s.mdu_start = 1'b1;
               ctrl_s.stall_f   = 1'b1;
               ctrl_s.stall_d   = 1'b1;
               ctrl_s.stall_e   = 1'b1;
               state_d          = HZ_MDU_WAIT;
            end else if (load_use_s || branch_haz_s) begin
               ctrl_s.stall_f = 1'b1;
               ctrl_s.stall_d = 1'b1;
               ctrl_s.flush_e = 1'b1;
            end else begin
               ctrl_s = '0;
            end
         end
         HZ_MDU_WAIT: begin
            if (mdu_done) begin
               state_d = HZ_RUN;
            end else begin
               ctrl_s.stall_f = 1'b1;
               ctrl_s.stall_d = 1'b1;
               ctrl_s.stall_e = 1'b1;
               ctrl_s.flush_m = 1'b1;
            end
         end
         HZ_MEM_WAIT: begin
            if (dmem_ready) begin
               to_cnt_d = 8'd0;
               state_d  = HZ_RUN;
            end else begin
               ctrl_s.stall_f = 1'b1;
               ctrl_s.stall_d = 1'b1;
               ctrl_s.stall_e = 1'b1;
               ctrl_s.stall_m = 1'b1;
               ctrl_s.flush_w = 1'b1;
               if (to_cnt_q == TO_LAST) begin
                  mem_err_d = 1'b1;
                  to_cnt_d  = 8'd0;
                  state_d   = HZ_RUN;
               end else begin
                  to_cnt_d = to_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d  = HZ_RUN;
            to_cnt_d = 8'd0;
         end
      endcase
   end

   // Saturating count of front-end stall cycles.
   always_comb begin
      if (ctrl_s.stall_f && (stall_cnt_q != {PERF_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + PERF_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HZ_RUN;
         to_cnt_q    <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Controls are gated by reset so nothing leaks out while it is asserted.
   always_comb begin
      stallF    = rst_n & ctrl_s.stall_f;
      stallD    = rst_n & ctrl_s.stall_d;
      stallE    = rst_n & ctrl_s.stall_e;
      stallM    = rst_n & ctrl_s.stall_m;
      flushE    = rst_n & ctrl_s.flush_e;
      flushM    = rst_n & ctrl_s.flush_m;
      flushW    = rst_n & ctrl_s.flush_w;
      mdu_start = rst_n & ctrl_s.mdu_start;
   end

   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a cycle-level behavioural
// model and a negedge compare process.
module tb_hazard_controller;

   localparam int TMO = 8;
   localparam int PW  = 6;
   localparam int SAT = 63;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] rsD, rtD, writeRegAddrE, writeRegAddrM;
   logic branchD, Regfile_weE, Regfile_weM, memToRegE, memToRegM;
   logic mduOpE, mdu_done, dmem_reqM, dmem_ready;
   logic stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err;
   logic [PW-1:0] stall_cycles;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int m_mode = 0;   // 0 running, 1 waiting on MDU, 2 waiting on memory
   int m_memc = 0;
   bit m_err  = 1'b0;
   int m_stl  = 0;

   hazard_controller #(.MEM_TIMEOUT(TMO), .PERF_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .rsD(rsD), .rtD(rtD), .branchD(branchD),
      .writeRegAddrE(writeRegAddrE), .writeRegAddrM(writeRegAddrM),
      .Regfile_weE(Regfile_weE), .Regfile_weM(Regfile_weM),
      .memToRegE(memToRegE), .memToRegM(memToRegM), .mduOpE(mduOpE),
      .mdu_done(mdu_done), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .mdu_start(mdu_start), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic bit hits(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      return (d != 5'd0) && (d == a || d == b);
   endfunction

   task automatic lit(input string name, input logic [8:0] act, input logic [8:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      rsD = 5'd0; rtD = 5'd0; branchD = 1'b0;
      writeRegAddrE = 5'd0; writeRegAddrM = 5'd0;
      Regfile_weE = 1'b0; Regfile_weM = 1'b0; memToRegE = 1'b0; memToRegM = 1'b0;
      mduOpE = 1'b0; mdu_done = 1'b0; dmem_reqM = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use3();
      memToRegE = 1'b1; Regfile_weE = 1'b1; writeRegAddrE = 5'd3; rsD = 5'd3;
   endtask

   // Per-cycle model and comparison, evaluated away from the rising edge.
   always @(negedge clk) begin
      bit sF, sD, sE, sM, fE, fM, fW, st;
      int nmode, nmemc;
      bit nerr;
      {sF, sD, sE, sM, fE, fM, fW, st} = 8'd0;
      if (!rst_n) begin
         m_mode = 0; m_memc = 0; m_err = 1'b0; m_stl = 0;
      end else begin
         nmode = m_mode; nmemc = m_memc; nerr = m_err;
         if (m_mode == 1) begin
            if (mdu_done) nmode = 0;
            else {sF, sD, sE, fM} = 4'b1111;
         end else if (m_mode == 2) begin
            if (dmem_ready) begin
               nmode = 0; nmemc = 0;
            end else begin
               {sF, sD, sE, sM, fW} = 5'b11111;
               nmemc = m_memc + 1;
               if (nmemc == TMO) begin nerr = 1'b1; nmode = 0; nmemc = 0; end
            end
         end else begin
            if (dmem_reqM && !dmem_ready) begin
               {sF, sD, sE, sM, fW} = 5'b11111; nmode = 2; nmemc = 0;
            end else if (mduOpE) begin
               {st, sF, sD, sE} = 4'b1111; nmode = 1;
            end else if ((memToRegE && Regfile_weE && hits(writeRegAddrE, rsD, rtD)) ||
                         (branchD && ((Regfile_weE && hits(writeRegAddrE, rsD, rtD)) ||
                                      (memToRegM && hits(writeRegAddrM, rsD, rtD))))) begin
               {sF, sD, fE} = 3'b111;
            end
         end
      end
      vectors++;
      if ({stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err} !==
          {sF, sD, sE, sM, fE, fM, fW, st, m_err}) begin
         miscompares++;
         $display("FAIL ctrl: got %b expected %b at %0t",
                  {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err},
                  {sF, sD, sE, sM, fE, fM, fW, st, m_err}, $time);
      end
      vectors++;
      if (int'(stall_cycles) != m_stl) begin
         miscompares++;
         $display("FAIL stall_cycles: got %0d expected %0d at %0t", stall_cycles, m_stl, $time);
      end
      if (rst_n) begin
         m_mode = nmode; m_memc = nmemc; m_err = nerr;
         if (sF && m_stl < SAT) m_stl++;
      end
   end

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      lit("reset_outs", {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err}, 9'd0);
      lit("reset_cnt", {3'd0, stall_cycles}, 9'd0);
      rst_n = 1'b1;
      tick();

      // load-use, then the bubble, then register 0
      load_use3(); #2;
      lit("lu_stall", {6'd0, stallF, stallD, flushE}, 9'b111);
      lit("lu_no_stallE", {8'd0, stallE}, 9'd0);
      tick(); idle(); #2;
      lit("lu_bubble", {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err}, 9'd0);
      tick();
      memToRegE = 1'b1; Regfile_weE = 1'b1; writeRegAddrE = 5'd0; rsD = 5'd0; #2;
      lit("lu_r0", {6'd0, stallF, stallD, flushE}, 9'd0);
      tick(); idle();

      // branch against ALU result in E, load in M, and non-branch
      branchD = 1'b1; rtD = 5'd5; Regfile_weE = 1'b1; writeRegAddrE = 5'd5; #2;
      lit("br_e", {6'd0, stallF, stallD, flushE}, 9'b111);
      tick(); idle();
      branchD = 1'b1; rtD = 5'd5; memToRegM = 1'b1; Regfile_weM = 1'b1; writeRegAddrM = 5'd5; #2;
      lit("br_m", {6'd0, stallF, stallD, flushE}, 9'b111);
      tick(); idle();
      rtD = 5'd5; Regfile_weE = 1'b1; writeRegAddrE = 5'd5;
      memToRegM = 1'b1; Regfile_weM = 1'b1; writeRegAddrM = 5'd5; #2;
      lit("br_off", {6'd0, stallF, stallD, flushE}, 9'd0);
      tick(); idle();

      // MDU with four waiting cycles
      mduOpE = 1'b1; #2;
      lit("cnt_before_mdu", {3'd0, stall_cycles}, 9'd3);
      lit("mdu_launch", {6'd0, mdu_start, stallE, flushM}, 9'b110);
      tick();
      for (int i = 0; i < 4; i++) begin
         #2;
         lit("mdu_wait", {6'd0, mdu_start, stallE, flushM}, 9'b011);
         tick();
      end
      mdu_done = 1'b1; #2;
      lit("mdu_done", {6'd0, mdu_start, stallE, flushM}, 9'd0);
      tick(); idle(); #2;
      lit("mdu_cnt", {3'd0, stall_cycles}, 9'd8);
      lit("mdu_back_run", {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err}, 9'd0);
      tick();

      // done coinciding with launch is ignored
      mduOpE = 1'b1; mdu_done = 1'b1; tick();
      mdu_done = 1'b0; #2;
      lit("mdu_done_ignored", {7'd0, stallE, flushM}, 9'b11);
      tick(); mdu_done = 1'b1; tick(); idle(); tick();

      // memory wait beats MDU launch
      dmem_reqM = 1'b1; mduOpE = 1'b1; #2;
      lit("mem_prio", {6'd0, mdu_start, stallM, flushW}, 9'b011);
      tick(); tick();
      dmem_ready = 1'b1; #2;
      lit("mem_release", {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err}, 9'd0);
      tick();
      dmem_reqM = 1'b0; dmem_ready = 1'b0; #2;
      lit("mdu_after_mem", {8'd0, mdu_start}, 9'd1);
      tick(); mduOpE = 1'b0; mdu_done = 1'b1; tick(); idle(); tick();

      // timeout: one entry cycle plus TMO waiting cycles
      dmem_reqM = 1'b1; tick();
      repeat (TMO - 1) tick();
      #2; lit("timeout_pre", {8'd0, mem_err}, 9'd0);
      tick();
      dmem_reqM = 1'b0; load_use3(); #2;
      lit("timeout_err", {8'd0, mem_err}, 9'd1);
      lit("timeout_run", {5'd0, stallF, stallD, stallE, flushE}, 9'b1101);
      tick(); idle(); tick(); #2;
      lit("err_sticky", {8'd0, mem_err}, 9'd1);

      // asynchronous reset in the middle of an MDU wait
      tick(); mduOpE = 1'b1; tick(); tick(); #2;
      lit("pre_reset_wait", {7'd0, stallE, flushM}, 9'b11);
      rst_n = 1'b0; #1;
      lit("async_outs", {stallF, stallD, stallE, stallM, flushE, flushM, flushW, mdu_start, mem_err}, 9'd0);
      lit("async_cnt", {3'd0, stall_cycles}, 9'd0);
      @(negedge clk); #2;
      rst_n = 1'b1; idle();
      tick(); load_use3(); #2;
      lit("post_reset_run", {5'd0, stallF, stallD, stallE, flushE}, 9'b1101);

      // saturation of the stall counter
      repeat (70) tick();
      #2; lit("cnt_saturate", {3'd0, stall_cycles}, 9'd63);
      idle(); tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
